// File: rtl/paddle_motion_ctrl_if.sv
// Button levels in, paddle positions and limit flags out, for the paddle motion controller.
// The master side (game logic / testbench) drives controls; the slave side is the controller.
interface paddle_motion_ctrl_if;
  logic        en;
  logic        bat_size;
  logic        p1p;
  logic        p1m;
  logic        p2p;
  logic        p2m;
  logic [10:0] p1_y;
  logic [10:0] p2_y;
  logic        p1_lim;
  logic        p2_lim;

  modport master (
    output en, bat_size, p1p, p1m, p2p, p2m,
    input  p1_y, p2_y, p1_lim, p2_lim
  );

  modport slave (
    input  en, bat_size, p1p, p1m, p2p, p2m,
    output p1_y, p2_y, p1_lim, p2_lim
  );
endinterface

// File: rtl/paddle_motion_ctrl.sv
// Turns debounced paddle buttons into top-edge Y positions for two players,
// with hold-to-accelerate stepping, screen clamping and bat-length-aware limits.
module paddle_motion_ctrl #(
  parameter int TICK_DIV    = 500000,
  parameter int ACCEL_TICKS = 8,
  parameter int MAX_STEP    = 8,
  parameter int V_RES       = 480,
  parameter int BAT_SMALL   = 48,
  parameter int BAT_LARGE   = 96
) (
  input  logic                clk,
  input  logic                rst,
  paddle_motion_ctrl_if.slave bus
);

  localparam int Y_W    = 11;
  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_W = $clog2(MAX_STEP + 1);
  localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);
  localparam logic [Y_W-1:0] Y_RESET = Y_W'((V_RES - BAT_SMALL) / 2);
  // A fresh press with single-tick acceleration already counts as one accelerated step.
  localparam logic [STEP_W-1:0] STEP_FRESH =
      (ACCEL_TICKS == 1 && MAX_STEP >= 2) ? STEP_W'(2) : STEP_W'(1);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_DOWN = 2'd1,
    DIR_UP   = 2'd2
  } dir_t;

  logic [CNT_W-1:0] tick_cnt_reg;
  logic             tick;
  logic [Y_W-1:0]   ymax;

  assign tick = (tick_cnt_reg == CNT_W'(TICK_DIV - 1));
  assign ymax = bus.bat_size ? Y_W'(V_RES - BAT_LARGE) : Y_W'(V_RES - BAT_SMALL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
    end
  end

  logic [1:0]          btn_plus;
  logic [1:0]          btn_minus;
  logic [1:0][Y_W-1:0] y_out;
  logic [1:0]          lim_out;

  assign btn_plus  = {bus.p2p, bus.p1p};
  assign btn_minus = {bus.p2m, bus.p1m};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_paddle
      logic [Y_W-1:0]    y_reg;
      logic              lim_reg;
      dir_t              dir_reg;
      logic [STEP_W-1:0] step_reg;
      logic [HOLD_W-1:0] hold_reg;

      dir_t           dir_req;
      logic [Y_W-1:0] move_amt;
      logic [Y_W:0]   y_sum;
      logic [Y_W-1:0] y_down;
      logic [Y_W-1:0] y_up;
      logic [Y_W-1:0] y_move;
      logic [Y_W-1:0] y_next;

      always_comb begin
        dir_req = DIR_IDLE;
        if (btn_plus[gi] && !btn_minus[gi]) begin
          dir_req = DIR_DOWN;
        end else if (btn_minus[gi] && !btn_plus[gi]) begin
          dir_req = DIR_UP;
        end

        move_amt = (dir_req == dir_reg) ? Y_W'(step_reg) : Y_W'(1);
        // One extra bit so y+step can never wrap before the ymax compare.
        y_sum  = {1'b0, y_reg} + {1'b0, move_amt};
        y_down = (y_sum > {1'b0, ymax}) ? ymax : y_sum[Y_W-1:0];
        y_up   = (y_reg < move_amt) ? '0 : (y_reg - move_amt);

        y_move = y_reg;
        if (dir_req == DIR_DOWN) begin
          y_move = y_down;
        end else if (dir_req == DIR_UP) begin
          y_move = y_up;
        end

        // Bat clamp wins over any movement on the same edge.
        y_next = y_reg;
        if (y_reg > ymax) begin
          y_next = ymax;
        end else if (tick && bus.en) begin
          y_next = y_move;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          y_reg    <= Y_RESET;
          lim_reg  <= 1'b0;
          dir_reg  <= DIR_IDLE;
          step_reg <= STEP_W'(1);
          hold_reg <= '0;
        end else begin
          y_reg   <= y_next;
          lim_reg <= (y_next == '0) || (y_next == ymax);
          if (tick) begin
            if (!bus.en || dir_req == DIR_IDLE) begin
              dir_reg  <= DIR_IDLE;
              step_reg <= STEP_W'(1);
              hold_reg <= '0;
            end else if (dir_req == dir_reg) begin
              if (hold_reg >= HOLD_W'(ACCEL_TICKS - 1)) begin
                hold_reg <= '0;
                if (step_reg < STEP_W'(MAX_STEP)) begin
                  step_reg <= step_reg + STEP_W'(1);
                end
              end else begin
                hold_reg <= hold_reg + HOLD_W'(1);
              end
            end else begin
              dir_reg  <= dir_req;
              step_reg <= STEP_FRESH;
              hold_reg <= HOLD_W'(1);
            end
          end
        end
      end

      assign y_out[gi]   = y_reg;
      assign lim_out[gi] = lim_reg;
    end
  endgenerate

  assign bus.p1_y   = y_out[0];
  assign bus.p2_y   = y_out[1];
  assign bus.p1_lim = lim_out[0];
  assign bus.p2_lim = lim_out[1];

endmodule
